// File: rtl/btn_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner_if
// Brief    : Raw button inputs and conditioned level/pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             any_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  any_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output any_pulse
    );
endinterface
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : Per-button 2-flop synchroniser, debouncer and press-pulse
//            generator. Define AUTOREPEAT_EN to add hold-to-repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    btn_conditioner_if.slave bus
);

    localparam int               c_CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] c_RELEASED = (ACTIVE_LOW != 0) ? '1 : '0;

`ifdef AUTOREPEAT_EN
    localparam int              c_HOLD_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                                 REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              c_HW           = $clog2(c_HOLD_MAX + 1);
    localparam logic [c_HW-1:0] c_DELAY_LAST   = c_HW'(REPEAT_DELAY - 1);
    localparam logic [c_HW-1:0] c_PERIOD_LAST  = c_HW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_s_sync;
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_pulse;

    // Plain flop pair; polarity is normalised only after the second stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= c_RELEASED;
            r_sync2 <= c_RELEASED;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s_sync = r_sync2 ^ c_RELEASED;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        state_t          r_state;
        logic [c_CW-1:0] r_cnt;
        logic            r_level_b;
        logic            r_pulse_b;
`ifdef AUTOREPEAT_EN
        logic [c_HW-1:0] r_hold;
        logic            r_repeating;
        logic [c_HW-1:0] w_hold_last;

        assign w_hold_last = r_repeating ? c_PERIOD_LAST : c_DELAY_LAST;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_level_b <= 1'b0;
                r_pulse_b <= 1'b0;
`ifdef AUTOREPEAT_EN
                r_hold      <= '0;
                r_repeating <= 1'b0;
`endif
            end else begin
                r_pulse_b <= 1'b0;
`ifdef AUTOREPEAT_EN
                // Hold tracking only survives while staying in PRESSED.
                r_hold      <= '0;
                r_repeating <= 1'b0;
`endif
                case (r_state)
                    ST_IDLE: begin
                        if (w_s_sync[gi]) begin
                            r_state <= ST_PRESS_WAIT;
                            r_cnt   <= c_CW'(1);
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s_sync[gi]) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state   <= ST_PRESSED;
                            r_cnt     <= '0;
                            r_level_b <= 1'b1;
                            r_pulse_b <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s_sync[gi]) begin
                            r_state <= ST_RELEASE_WAIT;
                            r_cnt   <= c_CW'(1);
                        end
`ifdef AUTOREPEAT_EN
                        else if (r_hold == w_hold_last) begin
                            r_pulse_b   <= 1'b1;
                            r_hold      <= '0;
                            r_repeating <= 1'b1;
                        end else begin
                            r_hold      <= r_hold + 1'b1;
                            r_repeating <= r_repeating;
                        end
`endif
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s_sync[gi]) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state   <= ST_IDLE;
                            r_cnt     <= '0;
                            r_level_b <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_level_b <= 1'b0;
                    end
                endcase
            end
        end

        assign w_level[gi] = r_level_b;
        assign w_pulse[gi] = r_pulse_b;
    end

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;
    assign bus.any_pulse = |w_pulse;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Directed and randomised bench for btn_conditioner against a
//            run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int N      = 5;
    localparam int DC     = 4;
    localparam int AL     = 1;
    localparam int RD     = 10;
    localparam int RP     = 3;
    localparam int BUDGET = 40;

    logic clk = 1'b0;
    logic reset;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DC),
        .ACTIVE_LOW     (AL),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: raw pipeline, length of the current disagreeing run,
    // and number of cycles the accepted press has been held steadily.
    bit m_p1[N], m_p2[N], m_level[N], m_pulse[N];
    int m_run[N], m_k[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_p1[i] = (AL != 0); m_p2[i] = (AL != 0);
            m_level[i] = 1'b0; m_pulse[i] = 1'b0;
            m_run[i] = 0; m_k[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit s;
        bit bounced;
        for (int i = 0; i < N; i++) begin
            s = m_p2[i] ^ (AL != 0);
            m_pulse[i] = 1'b0;
            if (s != m_level[i]) begin
                m_run[i]++;
                m_k[i] = 0;
                if (m_run[i] == DC) begin
                    m_level[i] = s;
                    m_run[i]   = 0;
                    m_pulse[i] = s;
                end
            end else begin
                bounced  = (m_run[i] > 0);
                m_run[i] = 0;
                if (m_level[i]) begin
                    if (bounced) m_k[i] = 0;
                    else begin
                        m_k[i]++;
`ifdef AUTOREPEAT_EN
                        if (m_k[i] == RD || (m_k[i] > RD && (m_k[i] - RD) % RP == 0))
                            m_pulse[i] = 1'b1;
`endif
                    end
                end
            end
            m_p2[i] = m_p1[i];
            m_p1[i] = bus.btn_raw[i];
        end
    endtask

    task automatic step();
        logic [N-1:0] el, ep;
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        for (int i = 0; i < N; i++) begin
            el[i] = m_level[i];
            ep[i] = m_pulse[i];
        end
        chk("level", {27'd0, bus.btn_level}, {27'd0, el});
        chk("pulse", {27'd0, bus.btn_pulse}, {27'd0, ep});
        chk("any",   {31'd0, bus.any_pulse}, {31'd0, |ep});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges until btn_pulse[idx] rises, or -1 when the budget runs out.
    task automatic wait_pulse(input int idx, output int edges);
        edges = -1;
        for (int e = 1; e <= BUDGET; e++) begin
            step();
            if (bus.btn_pulse[idx] === 1'b1) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int cnt;
        logic seen;
        int seg[N];

        reset = 1'b1;
        bus.btn_raw = '1;
        model_reset();
        #1;
        chk("rst_level", {27'd0, bus.btn_level}, 32'd0);
        chk("rst_pulse", {27'd0, bus.btn_pulse}, 32'd0);
        chk("rst_any",   {31'd0, bus.any_pulse}, 32'd0);
        steps(2);
        reset = 1'b0;
        steps(8);

        // Clean press on confirm
        bus.btn_raw[0] = 1'b0;
        wait_pulse(0, e);
        chk("t1_latency", e, 6);
        chk("t1_level", {31'd0, bus.btn_level[0]}, 32'd1);
        step();
        chk("t1_pulse_drop", {31'd0, bus.btn_pulse[0]}, 32'd0);
        steps(3);
        bus.btn_raw[0] = 1'b1;
        steps(10);

        // Short glitch is rejected
        seen = 1'b0;
        bus.btn_raw[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); seen |= bus.btn_level[2] | bus.btn_pulse[2]; end
        bus.btn_raw[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); seen |= bus.btn_level[2] | bus.btn_pulse[2]; end
        chk("t2_glitch", {31'd0, seen}, 32'd0);

        // Bouncy release
        bus.btn_raw[0] = 1'b0;
        steps(10);
        seen = 1'b0;
        bus.btn_raw[0] = 1'b1; step(); step();
        bus.btn_raw[0] = 1'b0; step();
        bus.btn_raw[0] = 1'b1;
        e = -1;
        for (int i = 1; i <= BUDGET; i++) begin
            step();
            seen |= bus.btn_pulse[0];
            if (bus.btn_level[0] === 1'b0) begin e = i; break; end
        end
        chk("t3_release_latency", e, 6);
        chk("t3_release_pulse", {31'd0, seen}, 32'd0);
        steps(4);

        // Simultaneous presses
        bus.btn_raw[1] = 1'b0;
        bus.btn_raw[4] = 1'b0;
        wait_pulse(1, e);
        chk("t4_latency", e, 6);
        chk("t4_pulse_vec", {27'd0, bus.btn_pulse}, 32'b10010);
        chk("t4_any", {31'd0, bus.any_pulse}, 32'd1);
        steps(3);

        // Reset mid-debounce with other keys held
        bus.btn_raw[3] = 1'b0;
        steps(3);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_level", {27'd0, bus.btn_level}, 32'd0);
        chk("t5_rst_pulse", {27'd0, bus.btn_pulse}, 32'd0);
        chk("t5_rst_any",   {31'd0, bus.any_pulse}, 32'd0);
        steps(2);
        reset = 1'b0;
        wait_pulse(3, e);
        chk("t5_latency", e, 6);
        bus.btn_raw = '1;
        steps(10);

        // Long hold: repeats only when the feature is built in
        bus.btn_raw[1] = 1'b0;
        wait_pulse(1, e);
        chk("t6_first", e, 6);
        cnt = 1;
        for (int i = 0; i < 17; i++) begin step(); cnt += int'(bus.btn_pulse[1]); end
`ifdef AUTOREPEAT_EN
        chk("t6_pulse_count", cnt, 4);
`else
        chk("t6_pulse_count", cnt, 1);
`endif
        bus.btn_raw[1] = 1'b1;
        steps(10);

        // Randomised segments of varying length on every button
        for (int i = 0; i < N; i++) seg[i] = $urandom_range(1, 12);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                seg[i]--;
                if (seg[i] <= 0) begin
                    bus.btn_raw[i] = ~bus.btn_raw[i];
                    seg[i] = $urandom_range(1, (bus.btn_raw[i] == 1'b0) ? 18 : 10);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
